// File: rtl/fila_pkg.sv
// Shared constants and FSM state type for the fila read-side drain controller.
package fila_pkg;

    localparam int FILA_WORD_W = 8;
    localparam int FILA_DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEQ     = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } drain_state_t;

endpackage

// File: rtl/drain_timer.sv
// Saturating idle counter: counts while inc is high, clears on clr, flags expiry at TIMEOUT-1.
module drain_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_r;

    // Idle count register, held at LAST once reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != LAST)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/fila_drain_ctrl.sv
// Read-side drain scheduler for the 8-entry fila with valid/ready output.
// Optional idle-timeout drain enabled by defining FILA_DRAIN_TIMEOUT_EN.
module fila_drain_ctrl
    import fila_pkg::*;
#(
    parameter int WORD_W    = FILA_WORD_W,
    parameter int DEPTH     = FILA_DEPTH,
    parameter int THRESHOLD = 4,
    parameter int MAX_BURST = 4,
    parameter int HEADROOM  = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic                       clk_10KHz,
    input  logic                       reset,
    input  logic [$clog2(DEPTH+1)-1:0] len_in,
    input  logic [WORD_W-1:0]          q_data_in,
    input  logic                       flush_in,
    input  logic                       ready_in,
    output logic                       dequeue_out,
    output logic [WORD_W-1:0]          data_out,
    output logic                       valid_out,
    output logic                       ack_out,
    output logic                       busy_out
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [LW-1:0] THRESH_L = LW'(THRESHOLD);
    localparam logic [LW-1:0] ACK_LIM  = LW'(DEPTH - HEADROOM);
    localparam logic [BW-1:0] MAXB     = BW'(MAX_BURST);

    drain_state_t  state_r, state_s;
    logic [BW-1:0] beats_r, beats_s;
    logic          flush_pend_r, flush_pend_s;
    logic          len_nz_s, flush_any_s, timer_exp_s;

    assign len_nz_s    = (len_in != '0);
    assign flush_any_s = flush_pend_r | flush_in;

`ifdef FILA_DRAIN_TIMEOUT_EN
    logic timer_inc_s;

    // Counting only while idle with a partial fila; anything else restarts it.
    assign timer_inc_s = (state_r == IDLE) && len_nz_s && (len_in < THRESH_L);

    drain_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk_10KHz),
        .rst_n   (reset),
        .clr     (!timer_inc_s),
        .inc     (timer_inc_s),
        .expired (timer_exp_s)
    );
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT);
    assign timer_exp_s      = 1'b0;
`endif

    // Next-state, beat count and pending-flush decisions.
    always_comb begin
        state_s      = state_r;
        beats_s      = beats_r;
        flush_pend_s = flush_any_s;
        case (state_r)
            IDLE: begin
                beats_s = '0;
                if (!len_nz_s) begin
                    flush_pend_s = 1'b0;
                end else begin
                    flush_pend_s = flush_any_s;
                end
                if (len_nz_s && ((len_in >= THRESH_L) || flush_any_s || timer_exp_s)) begin
                    state_s = DEQ;
                end else begin
                    state_s = IDLE;
                end
            end
            DEQ: begin
                beats_s = (beats_r == MAXB) ? beats_r : beats_r + BW'(1);
                state_s = CAPTURE;
            end
            CAPTURE: begin
                state_s = PRESENT;
            end
            PRESENT: begin
                if (!ready_in) begin
                    state_s = PRESENT;
                end else if (len_nz_s && (flush_any_s || (beats_r < MAXB))) begin
                    state_s = DEQ;
                end else begin
                    state_s = IDLE;
                    if (!len_nz_s) begin
                        flush_pend_s = 1'b0;
                    end else begin
                        flush_pend_s = flush_any_s;
                    end
                end
            end
            default: begin
                state_s      = IDLE;
                beats_s      = '0;
                flush_pend_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs (Moore outputs decoded from next state).
    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            beats_r      <= '0;
            flush_pend_r <= 1'b0;
            dequeue_out  <= 1'b0;
            valid_out    <= 1'b0;
            busy_out     <= 1'b0;
            ack_out      <= 1'b0;
            data_out     <= '0;
        end else begin
            state_r      <= state_s;
            beats_r      <= beats_s;
            flush_pend_r <= flush_pend_s;
            dequeue_out  <= (state_s == DEQ);
            valid_out    <= (state_s == PRESENT);
            busy_out     <= (state_s != IDLE);
            ack_out      <= (len_in < ACK_LIM);
            if (state_r == CAPTURE) begin
                data_out <= q_data_in;
            end else begin
                data_out <= data_out;
            end
        end
    end

endmodule
